ct_fcnvt_vector_ctrl_dp: RTL and testbench
==========================================

// Module: ct_fcnvt_vector_ctrl_dp
// PURPOSE
//  Parametrised control/datapath shell for the vector FP convert pipe (EX1-EX3), scaling the scalar convert control to LANES x 64-bit lanes.
//  EX1: decodes func and rounding mode; EX2 and EX3 carry a valid, the decoded size and a per-16-bit-chunk write mask built from vl.
//  EX3: masks the lane results, OR-reduces lane exceptions, and keeps a sticky fflags accumulator; global stall and flush are supported.
// PARAMETERS
//  LANES   2   number of 64-bit lanes; chunk count CH = 4*LANES
//  VLW     4   width of dp_ex1_vl; must hold values 0..CH
// PORTS
//  forever_cpuclk        in   1          clock
//  cpurst_b              in   1          reset, synchronous, active-low
//  ex1_inst_vld          in   1          EX1 holds a valid convert op
//  dp_ex1_func           in   20         func[16:13] size/width-mode, [3:0] si/float flags
//  dp_ex1_imm0           in   3          static rm; 3'b111 means dynamic
//  vfpu_yy_xx_rm         in   3          dynamic rm (frm)
//  dp_ex1_vl             in   VLW        active element count
//  pipe_stall            in   1          freeze all stages
//  rtu_yy_xx_flush       in   1          kill EX2/EX3 contents
//  fflags_clr            in   1          clear sticky accumulator
//  fcnvt_ex3_result      in   64*LANES   raw lane results
//  fcnvt_ex3_expt        in   5*LANES    per-lane {NV,DZ,OF,UF,NX}
//  ex1_rm                out  5          one-hot {rmm,rdn,rup,rtz,rne}
//  ex1_rm_illegal        out  1          resolved rm is 101/110/111
//  ex1_accept            out  1          ex1_inst_vld && !pipe_stall
//  ex2_dest_l16/l32/l64  out  1 each     EX2 destination size
//  ex2_dest_float        out  1          EX2 destination is FP
//  fcnvt_forward_r_vld   out  1          EX3 op retires this cycle
//  fcnvt_forward_result  out  64*LANES   masked result
//  fcnvt_forward_wmask   out  CH         per-16-bit-chunk write enable
//  fcnvt_ereg_forward_result out 5       OR of expt over active lanes
//  fflags_acc            out  5          sticky accumulated flags
// BEHAVIOUR
//  Clock and reset: one clock. The synchronous active-low reset clears every register on the clock edge.
//  Reset values: ex2/ex3 valid=0, all ex2_* outputs=0, wmask=0, fflags_acc=0, fcnvt_forward_r_vld=0.
//  Decode (combinational, EX1):
//   - src_l64 = f16 | f15&narrow; src_l32 = f15&!narrow | !f16&!f15&narrow; src_l16 = !f16&!f15&!narrow.
//   - widen = f14&!f13; narrow = !f14&f13; equal = !f14&!f13; sover = f14&f13.
//   - dest size = src size for equal; one step up for widen; one step down for narrow; 16<->64 for sover.
//   - dest_float = func[2].
//  Rounding mode:
//   - rm = dynamic rm if imm0==3'b111, else imm0.
//   - rm in 101/110/111: ex1_rm_illegal=1 and ex1_rm=5'b0. The op still flows down the pipe; the issue logic kills it.
//  Pipeline advance:
//   - When pipe_stall=0, every stage advances: ex2_vld<=ex1_inst_vld, ex3_vld<=ex2_vld.
//   - When pipe_stall=1, all registers hold.
//   - Latency: an op accepted in cycle t retires in cycle t+2 if there is no stall.
//  Flush:
//   - rtu_yy_xx_flush=1 clears ex2_vld and ex3_vld at the next edge. Flush overrides stall.
//   - An EX1 op in the same cycle as a flush is not captured.
//  Write mask (computed in EX1, registered into EX2 then EX3):
//   - Elements per chunk group: E = 1 for 16-bit, 2 for 32-bit, 4 for 64-bit destination.
//   - wmask[j] = ((j / E) < vl). vl=0 gives mask 0; vl >= CH/E gives all ones.
//  Retire:
//   - fcnvt_forward_r_vld = ex3_vld && !pipe_stall && !rtu_yy_xx_flush.
//   - Result chunks with wmask[j]=0 are driven 16'hFFFF (tail-agnostic).
//   - Lane i is active iff any of wmask[4i+3:4i] is set.
//   - fcnvt_ereg_forward_result = OR of expt over active lanes; it is 0 when there is no retire.
//  Flags accumulator:
//   - On retire, fflags_acc <= fflags_acc | ereg_result.
//   - fflags_clr clears it. Clear and retire in the same cycle: result = ereg_result only.
// TESTING
//  1. Issue one op: func equal, l32, FP; imm0=000; vl=3; LANES=2. -> r_vld in cycle t+2; wmask=8'b0011_1111; ex1_rm=5'b00001.
//  2. imm0=111 with frm=100 -> ex1_rm=5'b10000. imm0=101 -> ex1_rm_illegal=1 and ex1_rm=0.
//  3. Lane0 expt=5'b00001, lane1 expt=5'b10000, vl=1 at 64-bit -> ereg=5'b00001 (lane1 masked); result[127:64]=all ones.
//  4. Stall for 3 cycles while an op sits in EX2 -> r_vld stays 0 during the stall and asserts exactly once, 1 cycle after release.
//  5. Flush in the same cycle as a stalled EX3 op -> no retire, fflags_acc unchanged, pipe empty at the next edge.
//  6. Retire with NX while fflags_clr=1 -> fflags_acc=5'b00001. Assert cpurst_b=0 mid-pipe -> all valids and flags 0 after the next edge.

Source files
------------

// File: rtl/ct_fcnvt_vector_ctrl_dp.sv
// Vector FP convert pipe control/datapath shell (EX1-EX3): decode, rounding mode,
// chunk write-mask generation, lane result masking and sticky exception flags.
module ct_fcnvt_vector_ctrl_dp #(
  parameter int unsigned LANES = 2,
  parameter int unsigned VLW   = 4
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ex1_inst_vld,
  input  logic [19:0]           dp_ex1_func,
  input  logic [2:0]            dp_ex1_imm0,
  input  logic [2:0]            vfpu_yy_xx_rm,
  input  logic [VLW-1:0]        dp_ex1_vl,
  input  logic                  pipe_stall,
  input  logic                  rtu_yy_xx_flush,
  input  logic                  fflags_clr,
  input  logic [64*LANES-1:0]   fcnvt_ex3_result,
  input  logic [5*LANES-1:0]    fcnvt_ex3_expt,
  output logic [4:0]            ex1_rm,
  output logic                  ex1_rm_illegal,
  output logic                  ex1_accept,
  output logic                  ex2_dest_l16,
  output logic                  ex2_dest_l32,
  output logic                  ex2_dest_l64,
  output logic                  ex2_dest_float,
  output logic                  fcnvt_forward_r_vld,
  output logic [64*LANES-1:0]   fcnvt_forward_result,
  output logic [4*LANES-1:0]    fcnvt_forward_wmask,
  output logic [4:0]            fcnvt_ereg_forward_result,
  output logic [4:0]            fflags_acc
);

  localparam int unsigned CH = 4 * LANES;
  localparam int unsigned DW = 64 * LANES;

  // EX1 decode
  logic f16, f15, f14, f13;
  logic widen_c, narrow_c, equal_c, sover_c;
  logic src_l16_c, src_l32_c, src_l64_c;
  logic dst_l16_c, dst_l32_c, dst_l64_c, dst_float_c;
  logic [2:0] rm_sel_c;
  logic [4:0] rm_oh_c;
  logic rm_ill_c;
  logic [CH-1:0] wmask_c;
  int unsigned e_shift_c;
  logic func_unused;

  // pipeline state
  logic          ex2_vld_q, ex2_vld_d;
  logic          ex2_l16_q, ex2_l16_d;
  logic          ex2_l32_q, ex2_l32_d;
  logic          ex2_l64_q, ex2_l64_d;
  logic          ex2_float_q, ex2_float_d;
  logic [CH-1:0] ex2_wmask_q, ex2_wmask_d;
  logic          ex3_vld_q, ex3_vld_d;
  logic [CH-1:0] ex3_wmask_q, ex3_wmask_d;
  logic [4:0]    fflags_q, fflags_d;

  // EX3
  logic          retire_c;
  logic [LANES-1:0] lane_act_c;
  logic [4:0]    ereg_c;
  logic [DW-1:0] result_c;

  assign f16 = dp_ex1_func[16];
  assign f15 = dp_ex1_func[15];
  assign f14 = dp_ex1_func[14];
  assign f13 = dp_ex1_func[13];
  assign func_unused = ^{dp_ex1_func[19:17], dp_ex1_func[12:3], dp_ex1_func[1:0]};

  // size decode; 64-bit source takes priority where encodings overlap
  always_comb begin
    widen_c   = f14 & ~f13;
    narrow_c  = ~f14 & f13;
    equal_c   = ~f14 & ~f13;
    sover_c   = f14 & f13;
    src_l64_c = f16 | (f15 & narrow_c);
    src_l32_c = ~src_l64_c & ((f15 & ~narrow_c) | (~f16 & ~f15 & narrow_c));
    src_l16_c = ~f16 & ~f15 & ~narrow_c;
    dst_l16_c = 1'b0;
    dst_l32_c = 1'b0;
    dst_l64_c = 1'b0;
    if (equal_c) begin
      dst_l16_c = src_l16_c;
      dst_l32_c = src_l32_c;
      dst_l64_c = src_l64_c;
    end else if (widen_c) begin
      dst_l32_c = src_l16_c;
      dst_l64_c = src_l32_c | src_l64_c;
    end else if (narrow_c) begin
      dst_l16_c = src_l16_c | src_l32_c;
      dst_l32_c = src_l64_c;
    end else if (sover_c) begin
      dst_l16_c = src_l64_c;
      dst_l32_c = src_l32_c;
      dst_l64_c = src_l16_c;
    end
    dst_float_c = dp_ex1_func[2];
  end

  // rounding mode resolve and one-hot {rmm,rdn,rup,rtz,rne}
  always_comb begin
    rm_sel_c = (dp_ex1_imm0 == 3'b111) ? vfpu_yy_xx_rm : dp_ex1_imm0;
    rm_oh_c  = 5'b0;
    rm_ill_c = 1'b0;
    case (rm_sel_c)
      3'b000:  rm_oh_c = 5'b00001;
      3'b001:  rm_oh_c = 5'b00010;
      3'b010:  rm_oh_c = 5'b01000;
      3'b011:  rm_oh_c = 5'b00100;
      3'b100:  rm_oh_c = 5'b10000;
      default: rm_ill_c = 1'b1;
    endcase
  end

  // chunk j belongs to element j >> log2(E)
  always_comb begin
    e_shift_c = dst_l64_c ? 32'd2 : (dst_l32_c ? 32'd1 : 32'd0);
    wmask_c   = '0;
    for (int j = 0; j < int'(CH); j++) begin
      wmask_c[j] = (32'(j) >> e_shift_c) < 32'(dp_ex1_vl);
    end
  end

  assign ex1_rm         = rm_oh_c;
  assign ex1_rm_illegal = rm_ill_c;
  assign ex1_accept     = ex1_inst_vld & ~pipe_stall;

  // EX3 retire, lane masking and exception reduction
  always_comb begin
    retire_c = ex3_vld_q & ~pipe_stall & ~rtu_yy_xx_flush;
    ereg_c   = 5'b0;
    result_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      lane_act_c[i] = |ex3_wmask_q[4*i +: 4];
      if (retire_c && lane_act_c[i]) begin
        ereg_c = ereg_c | fcnvt_ex3_expt[5*i +: 5];
      end
    end
    for (int j = 0; j < int'(CH); j++) begin
      result_c[16*j +: 16] = ex3_wmask_q[j] ? fcnvt_ex3_result[16*j +: 16] : 16'hFFFF;
    end
  end

  // next state: stall holds, flush kills valids and wins over stall
  always_comb begin
    ex2_vld_d   = ex2_vld_q;
    ex2_l16_d   = ex2_l16_q;
    ex2_l32_d   = ex2_l32_q;
    ex2_l64_d   = ex2_l64_q;
    ex2_float_d = ex2_float_q;
    ex2_wmask_d = ex2_wmask_q;
    ex3_vld_d   = ex3_vld_q;
    ex3_wmask_d = ex3_wmask_q;
    if (!pipe_stall) begin
      ex2_vld_d   = ex1_inst_vld;
      ex2_l16_d   = dst_l16_c;
      ex2_l32_d   = dst_l32_c;
      ex2_l64_d   = dst_l64_c;
      ex2_float_d = dst_float_c;
      ex2_wmask_d = wmask_c;
      ex3_vld_d   = ex2_vld_q;
      ex3_wmask_d = ex2_wmask_q;
    end
    if (rtu_yy_xx_flush) begin
      ex2_vld_d = 1'b0;
      ex3_vld_d = 1'b0;
    end
    fflags_d = fflags_clr ? ereg_c : (fflags_q | ereg_c);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      ex2_vld_q   <= 1'b0;
      ex2_l16_q   <= 1'b0;
      ex2_l32_q   <= 1'b0;
      ex2_l64_q   <= 1'b0;
      ex2_float_q <= 1'b0;
      ex2_wmask_q <= '0;
      ex3_vld_q   <= 1'b0;
      ex3_wmask_q <= '0;
      fflags_q    <= 5'b0;
    end else begin
      ex2_vld_q   <= ex2_vld_d;
      ex2_l16_q   <= ex2_l16_d;
      ex2_l32_q   <= ex2_l32_d;
      ex2_l64_q   <= ex2_l64_d;
      ex2_float_q <= ex2_float_d;
      ex2_wmask_q <= ex2_wmask_d;
      ex3_vld_q   <= ex3_vld_d;
      ex3_wmask_q <= ex3_wmask_d;
      fflags_q    <= fflags_d;
    end
  end

  assign ex2_dest_l16              = ex2_l16_q;
  assign ex2_dest_l32              = ex2_l32_q;
  assign ex2_dest_l64              = ex2_l64_q;
  assign ex2_dest_float            = ex2_float_q;
  assign fcnvt_forward_r_vld       = retire_c;
  assign fcnvt_forward_result      = result_c;
  assign fcnvt_forward_wmask       = ex3_wmask_q;
  assign fcnvt_ereg_forward_result = ereg_c;
  assign fflags_acc                = fflags_q;

endmodule

// File: tb/tb_ct_fcnvt_vector_ctrl_dp.sv
// Directed bench for the vector convert control/datapath shell (LANES=2).
module tb_ct_fcnvt_vector_ctrl_dp;

  logic         clk;
  logic         rst_b;
  logic         vld;
  logic [19:0]  func;
  logic [2:0]   imm0;
  logic [2:0]   frm;
  logic [3:0]   vl;
  logic         stall;
  logic         flush;
  logic         clr;
  logic [127:0] res_in;
  logic [9:0]   expt;
  logic [4:0]   rm;
  logic         rm_ill;
  logic         accept;
  logic         l16, l32, l64, dfloat;
  logic         r_vld;
  logic [127:0] res_out;
  logic [7:0]   wmask;
  logic [4:0]   ereg;
  logic [4:0]   acc;

  int total = 0;
  int bad   = 0;

  ct_fcnvt_vector_ctrl_dp #(.LANES(2), .VLW(4)) dut (
    .forever_cpuclk            (clk),
    .cpurst_b                  (rst_b),
    .ex1_inst_vld              (vld),
    .dp_ex1_func               (func),
    .dp_ex1_imm0               (imm0),
    .vfpu_yy_xx_rm             (frm),
    .dp_ex1_vl                 (vl),
    .pipe_stall                (stall),
    .rtu_yy_xx_flush           (flush),
    .fflags_clr                (clr),
    .fcnvt_ex3_result          (res_in),
    .fcnvt_ex3_expt            (expt),
    .ex1_rm                    (rm),
    .ex1_rm_illegal            (rm_ill),
    .ex1_accept                (accept),
    .ex2_dest_l16              (l16),
    .ex2_dest_l32              (l32),
    .ex2_dest_l64              (l64),
    .ex2_dest_float            (dfloat),
    .fcnvt_forward_r_vld       (r_vld),
    .fcnvt_forward_result      (res_out),
    .fcnvt_forward_wmask       (wmask),
    .fcnvt_ereg_forward_result (ereg),
    .fflags_acc                (acc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_b = 1'b0; vld = 1'b0; func = '0; imm0 = '0; frm = '0; vl = '0;
    stall = 1'b0; flush = 1'b0; clr = 1'b0; res_in = '0; expt = '0;
    next_cycle(); next_cycle();
    #1;
    total++;
    if ({r_vld, l16, l32, l64, dfloat} !== 5'b0) begin
      bad++; $display("FAIL reset_ctl got=%b want=00000", {r_vld, l16, l32, l64, dfloat});
    end
    total++;
    if ({wmask, acc, ereg} !== 18'b0) begin
      bad++; $display("FAIL reset_regs wmask=%h acc=%b ereg=%b want all 0", wmask, acc, ereg);
    end
    rst_b = 1'b1;
    next_cycle();
  endtask

  task automatic test_rm();
    imm0 = 3'b111; frm = 3'b100; #1;
    total++;
    if (rm !== 5'b10000 || rm_ill !== 1'b0) begin
      bad++; $display("FAIL rm_dyn_rmm got=%b ill=%b want=10000", rm, rm_ill);
    end
    frm = 3'b010; #1;
    total++;
    if (rm !== 5'b01000) begin bad++; $display("FAIL rm_dyn_rdn got=%b want=01000", rm); end
    imm0 = 3'b011; #1;
    total++;
    if (rm !== 5'b00100) begin bad++; $display("FAIL rm_rup got=%b want=00100", rm); end
    imm0 = 3'b101; #1;
    total++;
    if (rm !== 5'b00000 || rm_ill !== 1'b1) begin
      bad++; $display("FAIL rm_illegal got=%b ill=%b want=00000 ill=1", rm, rm_ill);
    end
    imm0 = 3'b111; frm = 3'b110; #1;
    total++;
    if (rm_ill !== 1'b1) begin bad++; $display("FAIL rm_dyn_illegal got=%b want=1", rm_ill); end
    imm0 = 3'b000;
    next_cycle();
  endtask

  task automatic test_basic();
    vld = 1'b1; func = 20'h08004; imm0 = 3'b000; vl = 4'd3;
    res_in = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF; #1;
    total++;
    if (rm !== 5'b00001 || accept !== 1'b1) begin
      bad++; $display("FAIL basic_ex1 rm=%b acc=%b want rm=00001 accept=1", rm, accept);
    end
    next_cycle(); vld = 1'b0; #1;
    total++;
    if ({l16, l32, l64, dfloat, r_vld} !== 5'b01010) begin
      bad++; $display("FAIL basic_ex2 got=%b want=01010", {l16, l32, l64, dfloat, r_vld});
    end
    next_cycle(); #1;
    total++;
    if (r_vld !== 1'b1 || wmask !== 8'b0011_1111) begin
      bad++; $display("FAIL basic_retire r_vld=%b wmask=%b want 1 00111111", r_vld, wmask);
    end
    total++;
    if (res_out !== 128'hFFFF_FFFF_4455_6677_8899_AABB_CCDD_EEFF) begin
      bad++; $display("FAIL basic_result got=%h", res_out);
    end
    next_cycle(); #1;
    total++;
    if (r_vld !== 1'b0) begin bad++; $display("FAIL basic_single r_vld=%b want=0", r_vld); end
  endtask

  task automatic test_wmask();
    logic [19:0] tf [8];
    logic [3:0]  tv [8];
    logic [7:0]  tm [8];
    logic [2:0]  td [8];
    tf = '{20'h00000, 20'h00000, 20'h00000, 20'h00000, 20'h04000, 20'h12000, 20'h06000, 20'h10000};
    tv = '{4'd0,      4'd5,      4'd8,      4'd15,     4'd3,      4'd1,      4'd1,      4'd2};
    tm = '{8'h00,     8'h1F,     8'hFF,     8'hFF,     8'h3F,     8'h03,     8'h0F,     8'hFF};
    td = '{3'b001,    3'b001,    3'b001,    3'b001,    3'b010,    3'b010,    3'b100,    3'b100};
    for (int k = 0; k < 8; k++) begin
      vld = 1'b1; func = tf[k]; vl = tv[k];
      next_cycle(); vld = 1'b0; #1;
      total++;
      if ({l64, l32, l16} !== td[k]) begin
        bad++; $display("FAIL wmask_dest[%0d] got=%b want=%b", k, {l64, l32, l16}, td[k]);
      end
      next_cycle(); #1;
      total++;
      if (r_vld !== 1'b1 || wmask !== tm[k]) begin
        bad++; $display("FAIL wmask[%0d] r_vld=%b got=%b want=%b", k, r_vld, wmask, tm[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_lane_mask();
    vld = 1'b1; func = 20'h10000; vl = 4'd1;
    next_cycle(); vld = 1'b0;
    next_cycle();
    expt = {5'b10000, 5'b00001};
    res_in = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_5678_9ABC_DEF0}; #1;
    total++;
    if (ereg !== 5'b00001 || wmask !== 8'h0F) begin
      bad++; $display("FAIL lane_ereg ereg=%b wmask=%h want 00001 0f", ereg, wmask);
    end
    total++;
    if (res_out !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0}) begin
      bad++; $display("FAIL lane_result got=%h", res_out);
    end
    next_cycle(); expt = '0; #1;
    total++;
    if (acc !== 5'b00001) begin bad++; $display("FAIL lane_acc got=%b want=00001", acc); end
  endtask

  task automatic test_stall();
    vld = 1'b1; func = 20'h08004; vl = 4'd8;
    next_cycle(); vld = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (r_vld !== 1'b0 || l32 !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] r_vld=%b l32=%b want 0 1", k, r_vld, l32);
      end
      next_cycle();
    end
    stall = 1'b0; #1;
    total++;
    if (r_vld !== 1'b0) begin bad++; $display("FAIL stall_release r_vld=%b want=0", r_vld); end
    next_cycle(); #1;
    total++;
    if (r_vld !== 1'b1) begin bad++; $display("FAIL stall_retire r_vld=%b want=1", r_vld); end
    next_cycle(); #1;
    total++;
    if (r_vld !== 1'b0) begin bad++; $display("FAIL stall_once r_vld=%b want=0", r_vld); end
  endtask

  task automatic test_flush();
    vld = 1'b1; func = 20'h08004; vl = 4'd8;
    next_cycle(); vld = 1'b0;
    next_cycle(); stall = 1'b1; #1;
    total++;
    if (r_vld !== 1'b0) begin bad++; $display("FAIL flush_stalled r_vld=%b want=0", r_vld); end
    next_cycle(); flush = 1'b1; vld = 1'b1; expt = 10'h3FF; #1;
    total++;
    if (r_vld !== 1'b0 || ereg !== 5'b0) begin
      bad++; $display("FAIL flush_noretire r_vld=%b ereg=%b want 0 0", r_vld, ereg);
    end
    next_cycle(); flush = 1'b0; stall = 1'b0; vld = 1'b0; expt = '0; #1;
    total++;
    if (r_vld !== 1'b0 || acc !== 5'b00001) begin
      bad++; $display("FAIL flush_after r_vld=%b acc=%b want 0 00001", r_vld, acc);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle(); #1;
      total++;
      if (r_vld !== 1'b0) begin bad++; $display("FAIL flush_empty[%0d] r_vld=%b want=0", k, r_vld); end
    end
  endtask

  task automatic test_clr_and_reset();
    vld = 1'b1; func = 20'h08004; vl = 4'd8;
    next_cycle(); vld = 1'b0;
    next_cycle(); expt = {5'b00000, 5'b10000}; #1;
    total++;
    if (r_vld !== 1'b1 || ereg !== 5'b10000) begin
      bad++; $display("FAIL clr_pre r_vld=%b ereg=%b want 1 10000", r_vld, ereg);
    end
    next_cycle(); expt = '0; vld = 1'b1; #1;
    total++;
    if (acc !== 5'b10001) begin bad++; $display("FAIL clr_accum got=%b want=10001", acc); end
    next_cycle(); vld = 1'b0;
    next_cycle(); expt = {5'b00000, 5'b00001}; clr = 1'b1;
    next_cycle(); expt = '0; clr = 1'b0; #1;
    total++;
    if (acc !== 5'b00001) begin bad++; $display("FAIL clr_retire got=%b want=00001", acc); end
    vld = 1'b1;
    next_cycle(); vld = 1'b0; rst_b = 1'b0;
    next_cycle(); #1;
    total++;
    if ({r_vld, l32, acc, wmask} !== 15'b0) begin
      bad++; $display("FAIL midpipe_reset r_vld=%b l32=%b acc=%b wmask=%h want all 0", r_vld, l32, acc, wmask);
    end
    rst_b = 1'b1;
    next_cycle(); #1;
    total++;
    if (r_vld !== 1'b0) begin bad++; $display("FAIL midpipe_empty r_vld=%b want=0", r_vld); end
  endtask

  initial begin
    test_reset();
    test_rm();
    test_basic();
    test_wmask();
    test_lane_mask();
    test_stall();
    test_flush();
    test_clr_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
